// File: rtl/ram_bus_master.sv
// ram_bus_master
//   Single-port asynchronous-style RAM master. It accepts one read or write
//   request at a time on a valid/ready handshake and sequences the RAM
//   chip-select, write-enable and output-enable strobes.
//   - Write: one WRITE cycle.
//   - Read: a READ cycle, then a CAPTURE cycle. The read data is sampled at
//     the edge that closes CAPTURE, and rsp_valid pulses in the following
//     cycle.
//
// Parameters
//   ADDR_WIDTH  RAM address width (default 4)
//   DATA_WIDTH  RAM data width    (default 16)
//
// Ports
//   clk, rst                         clock; asynchronous active-high reset
//   req_valid/req_ready              request handshake; ready only in IDLE
//   req_we, req_addr, req_wdata      request fields, latched at acceptance
//   rsp_valid, rsp_rdata             one-cycle read-response pulse and held data
//   ram_cs, ram_we, ram_oe, ram_addr registered RAM controls
//   ram_data                         shared bidirectional data bus, driven only in WRITE
//
// Configuration
//   RAM_BUS_MASTER_TURNAROUND_EN  When defined, a one-cycle TURN state with
//                                 all RAM controls low is inserted after
//                                 CAPTURE. This gives the RAM time to release
//                                 the bus before the next access.
module ram_bus_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

`ifdef RAM_BUS_MASTER_TURNAROUND_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, TURN} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;
`endif

  state_t                state;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;

  // req_ready is high exactly when the FSM is in IDLE, so this is the handshake.
  assign accept = req_valid && req_ready;

  // The bus is driven only while drive_en is set, i.e. only in WRITE.
  assign ram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      drive_en  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            ram_cs    <= 1'b1;
            ram_addr  <= req_addr;
            if (req_we) begin
              state    <= WRITE;
              ram_we   <= 1'b1;
              drive_en <= 1'b1;
            end else begin
              state  <= READ;
              ram_oe <= 1'b1;
            end
          end
        end
        WRITE: begin
          state     <= IDLE;
          ram_cs    <= 1'b0;
          ram_we    <= 1'b0;
          drive_en  <= 1'b0;
          req_ready <= 1'b1;
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          // The RAM has been driving the bus for two cycles, so the data is stable here.
          rsp_rdata <= ram_data;
          rsp_valid <= 1'b1;
          ram_cs    <= 1'b0;
          ram_oe    <= 1'b0;
`ifdef RAM_BUS_MASTER_TURNAROUND_EN
          state     <= TURN;
`else
          state     <= IDLE;
          req_ready <= 1'b1;
`endif
        end
`ifdef RAM_BUS_MASTER_TURNAROUND_EN
        TURN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
`endif
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          ram_cs    <= 1'b0;
          ram_we    <= 1'b0;
          ram_oe    <= 1'b0;
          drive_en  <= 1'b0;
        end
      endcase
    end
  end

  // Write data is a data register: no reset, loaded only on acceptance.
  always_ff @(posedge clk) begin
    if (accept) wdata_q <= req_wdata;
  end

endmodule

// File: tb/tb_ram_bus_master.sv
module tb_ram_bus_master;

`ifdef RAM_BUS_MASTER_TURNAROUND_EN
  localparam int TURNI = 1;
`else
  localparam int TURNI = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        ram_cs, ram_we, ram_oe;
  logic [3:0]  ram_addr;
  wire  [15:0] ram_data;

  int checks = 0;
  int errors = 0;

  // Environment RAM: the device on the far side of the bus.
  logic [15:0] env_mem [16];
  // Reference model: the memory contents implied by accepted writes.
  logic [15:0] ref_mem [16];

  ram_bus_master #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  assign ram_data = (ram_cs && ram_oe) ? env_mem[ram_addr] : 16'bz;

  always @(posedge clk) begin
    if (ram_cs && ram_we) env_mem[ram_addr] <= ram_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: outside WRITE the master must not drive the bus. When the RAM
  // drives it, any extra driver would corrupt the value seen.
  always @(negedge clk) begin
    if (ram_oe)
      chk("bus_read_clean", ram_data, env_mem[ram_addr]);
    else if (!ram_we)
      chk("bus_idle_z", ($isunknown(ram_data) || ram_data === 16'h0), 1);
  end

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) chk("ready_timeout", 0, 1);
  endtask

  // Called at a negedge. The request is accepted at the following posedge (edge N).
  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    ref_mem[a] = d;
    @(negedge clk);  // cycle N+1
    req_valid = 1'b0; req_we = 1'b0; req_addr = ~a; req_wdata = ~d;
    chk("wr_cs", ram_cs, 1);
    chk("wr_we", ram_we, 1);
    chk("wr_oe", ram_oe, 0);
    chk("wr_addr", ram_addr, a);
    chk("wr_data", ram_data, d);
    chk("wr_ready", req_ready, 0);
    @(negedge clk);  // cycle N+2
    chk("wr_done_ready", req_ready, 1);
    chk("wr_done_cs", ram_cs, 0);
  endtask

  // When hold is set, req_valid stays high through the read: first with a
  // garbage read request, then with a write (a2, d2) that must be accepted
  // exactly when the master returns to IDLE.
  task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input bit hold,
                         input logic [3:0] a2, input logic [15:0] d2);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);  // cycle N+1: READ
    chk("rd_cs", ram_cs, 1);
    chk("rd_we", ram_we, 0);
    chk("rd_oe", ram_oe, 1);
    chk("rd_addr", ram_addr, a);
    chk("rd_ready", req_ready, 0);
    req_valid = hold; req_addr = 4'($urandom); req_wdata = 16'($urandom);
    @(negedge clk);  // cycle N+2: CAPTURE
    chk("cap_cs", ram_cs, 1);
    chk("cap_oe", ram_oe, 1);
    chk("cap_addr", ram_addr, a);
    chk("cap_rsp_valid", rsp_valid, 0);
    req_we = hold; req_addr = a2; req_wdata = d2;
    @(negedge clk);  // cycle N+3
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp);
    chk("rsp_ready", req_ready, (TURNI == 0));
    chk("rsp_cs", ram_cs, 0);
    chk("rsp_oe", ram_oe, 0);
    if (hold) begin
      ref_mem[a2] = d2;
      @(negedge clk);  // cycle N+4
      chk("hold_rsp_pulse", rsp_valid, 0);
      chk("hold_rdata_kept", rsp_rdata, exp);
      chk("hold_cs_n4", ram_cs, (TURNI == 0));
      chk("hold_ready_n4", req_ready, (TURNI == 1));
      for (int k = 0; k < TURNI; k++) @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0;
      chk("hold_wr_cs", ram_cs, 1);
      chk("hold_wr_we", ram_we, 1);
      chk("hold_wr_addr", ram_addr, a2);
      chk("hold_wr_data", ram_data, d2);
      @(negedge clk);
      chk("hold_wr_done", req_ready, 1);
    end else begin
      req_valid = 1'b0; req_we = 1'b0;
      @(negedge clk);  // cycle N+4
      chk("rsp_pulse", rsp_valid, 0);
      chk("rdata_kept", rsp_rdata, exp);
      chk("ready_n4", req_ready, 1);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    tbl[0] = '{1'b1, 4'h3, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b0, 4'h3, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b1, 4'h0, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 4'hF, 16'hFFFF, 16'h0000};
    tbl[4] = '{1'b0, 4'hF, 16'h0000, 16'hFFFF};
    tbl[5] = '{1'b0, 4'h0, 16'h0000, 16'h0000};
    tbl[6] = '{1'b1, 4'h3, 16'h1234, 16'h0000};
    tbl[7] = '{1'b0, 4'h3, 16'h0000, 16'h1234};

    // Reset state
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_oe", ram_oe, 0);
    chk("rst_addr", ram_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].we) do_write(tbl[i].addr, tbl[i].wdata);
      else           do_read(tbl[i].addr, tbl[i].exp, 1'b0, 4'h0, 16'h0);
    end

    // Back-to-back writes, then reads in order
    for (int i = 0; i < 16; i++) do_write(4'(i), 16'(16'h1000 + i));
    for (int i = 0; i < 16; i++) do_read(4'(i), 16'(16'h1000 + i), 1'b0, 4'h0, 16'h0);

    // Inputs held valid and changing during a read, followed by a queued write
    do_read(4'h3, 16'h1003, 1'b1, 4'h7, 16'hA5A5);
    do_read(4'h7, 16'hA5A5, 1'b0, 4'h0, 16'h0);

    // Reset in the middle of a read of address 5
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h5;
    @(negedge clk);
    chk("abort_rd_oe", ram_oe, 1);
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("abort_ready", req_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rdata", rsp_rdata, 0);
    chk("abort_cs", ram_cs, 0);
    chk("abort_oe", ram_oe, 0);
    chk("abort_we", ram_we, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_bus_z", ($isunknown(ram_data) || ram_data === 16'h0), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    do_write(4'h5, 16'h5555);
    do_read(4'h5, 16'h5555, 1'b0, 4'h0, 16'h0);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  a, a2;
      logic [15:0] d, d2;
      a = 4'($urandom); a2 = 4'($urandom);
      d = 16'($urandom); d2 = 16'($urandom);
      if ($urandom_range(1, 0) == 1) do_write(a, d);
      else do_read(a, ref_mem[a], ($urandom_range(3, 0) == 0), a2, d2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bus_master.md
RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, RAM data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request offered.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  request address.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle pulse: rsp_rdata holds read data.
REQ-011 SHALL have port rsp_rdata  output  DATA_WIDTH  captured read data.
REQ-012 SHALL have port ram_cs  output  1  RAM chip select.
REQ-013 SHALL have port ram_we  output  1  RAM write enable.
REQ-014 SHALL have port ram_oe  output  1  RAM output enable; 1 = RAM drives ram_data.
REQ-015 SHALL have port ram_addr  output  ADDR_WIDTH  RAM address.
REQ-016 SHALL have port ram_data  inout  DATA_WIDTH  shared bidirectional RAM data bus.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, CAPTURE (plus TURN per REQ-031).
REQ-018 SHALL drive all ram_* controls, req_ready and rsp_valid from registers, not combinationally from inputs.
REQ-019 SHALL assert req_ready only in IDLE.
REQ-020 SHALL accept a request on the clk edge where req_valid and req_ready are both 1.
REQ-021 SHALL latch req_we, req_addr and req_wdata at acceptance, then enter WRITE (req_we=1) or READ (req_we=0).
REQ-022 SHALL ignore req_valid and all req_* inputs outside IDLE; no queuing.
REQ-023 WRITE, 1 cycle: ram_cs=1, ram_we=1, ram_oe=0, ram_addr=latched address, ram_data driven with latched wdata; next state IDLE.
REQ-024 READ, 1 cycle: ram_cs=1, ram_we=0, ram_oe=1, ram_data high-Z; next state CAPTURE.
REQ-025 CAPTURE, 1 cycle: same controls as READ; sample ram_data into rsp_rdata at the closing edge.
REQ-026 SHALL pulse rsp_valid for exactly one cycle, the cycle after CAPTURE; rsp_rdata SHALL hold its value until the next capture.
REQ-027 In IDLE: ram_cs=0, ram_we=0, ram_oe=0, ram_data high-Z; ram_addr keeps its last value.
REQ-028 SHALL drive ram_data only in WRITE; never while ram_oe=1 (no bus contention).
REQ-029 Latency, acceptance at edge N: write occupies cycle N+1, req_ready=1 at N+2. Read: READ at N+1, CAPTURE at N+2, rsp_valid=1 at N+3.
REQ-030 Back-to-back writes SHALL sustain one write per 2 cycles.

Configuration
REQ-031 Macro RAM_BUS_MASTER_TURNAROUND_EN defined: after CAPTURE, enter TURN for 1 cycle (all ram_* controls 0, ram_data high-Z, req_ready=0), then IDLE; rsp_valid timing unchanged (N+3), req_ready=1 at N+4.
REQ-032 Macro undefined: CAPTURE SHALL go directly to IDLE (req_ready=1 at N+3); no TURN state logic SHALL exist.

Reset
REQ-033 rst=1 SHALL immediately, without waiting for clk, force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0 and ram_data high-Z.
REQ-034 Reset during WRITE, READ, CAPTURE or TURN SHALL abort the transaction; no rsp_valid SHALL follow.

Verification
REQ-035 Write 0xBEEF to addr 0x3, then read addr 0x3 -> rsp_valid at N+3 of the read with rsp_rdata=0xBEEF.
REQ-036 16 back-to-back writes, addr i with data 0x1000+i, then 16 reads -> each rsp_rdata=0x1000+i, in order; one write per 2 cycles.
REQ-037 Assert rst mid-READ (addr 0x5) -> outputs at reset values within the same cycle; no rsp_valid pulse; next request accepted normally.
REQ-038 Every cycle, a bench assertion that ram_data is high-Z whenever ram_oe=1 or the state is not WRITE -> no violations across REQ-035..037.
REQ-039 Build with and without RAM_BUS_MASTER_TURNAROUND_EN, issue a read then a write held valid -> write accepted at N+4 or N+3 respectively.
REQ-040 req_valid=1 with req_addr changing during a read -> changes ignored; rsp_rdata reflects the originally latched address.
